// File: rtl/unified_buffer_read_sequencer.sv
// Read-address sequencer for the unified buffer: walks a job's input tiles in
// outer-product order (x outer, y re-read per x) with downstream backpressure.
module unified_buffer_read_sequencer #(
  parameter int ADDR_W       = 12,
  parameter int DIM_W        = 8,
  parameter int TILE_LOG2    = 5,
  parameter int TCNT_W       = 3,
  parameter int WAIT_PER_COL = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DIM_W-1:0]  U_dim1_i,
  input  logic [DIM_W-1:0]  V_dim1_i,
  input  logic [DIM_W-1:0]  ITER_dim1_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [DIM_W-1:0]  row_stride_i,
  input  logic              weights_rdy_i,
  input  logic              rd_ready_i,
  input  logic              abort_i,
  output logic              cfg_ready_o,
  output logic              busy_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [TCNT_W-1:0] tile_x_o,
  output logic [TCNT_W-1:0] tile_y_o,
  output logic              last_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_W = 2'd1, READ = 2'd2} state_t;

  state_t              state;
  logic [DIM_W-1:0]    beat;
  logic [DIM_W-1:0]    v_r;
  logic [DIM_W-1:0]    stride_r;
  logic [TCNT_W-1:0]   ymax_r;
  logic [TCNT_W-1:0]   xmax_r;
  logic [ADDR_W-1:0]   base_r;

  logic                fire;
  logic                accept;
  logic                beat_end;
  logic                y_end;
  logic                x_step;
  logic                next_last;
  logic [DIM_W-1:0]    next_beat;
  logic [TCNT_W-1:0]   next_y;
  logic [TCNT_W-1:0]   next_x;
  logic [ADDR_W-1:0]   next_addr;

  // Product is formed at full address width, so any overflow wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] tile_base(input logic [TCNT_W-1:0] x,
                                                  input logic [ADDR_W-1:0] b,
                                                  input logic [DIM_W-1:0]  s);
    return b + ADDR_W'(x) * ADDR_W'(s);
  endfunction

  assign busy_o      = (state != IDLE);
  assign cfg_ready_o = (state == IDLE) | ((state == READ) & last_o & rd_ready_i);
  assign accept      = start_i & cfg_ready_o & ~abort_i;

  always_comb begin
    fire      = rd_en_o & rd_ready_i;
    beat_end  = (beat == v_r);
    y_end     = (tile_y_o == ymax_r);
    x_step    = beat_end & y_end;
    next_beat = beat_end ? '0 : beat + DIM_W'(1);
    next_y    = beat_end ? (y_end ? '0 : tile_y_o + TCNT_W'(1)) : tile_y_o;
    next_x    = x_step ? tile_x_o + TCNT_W'(1) : tile_x_o;
    next_addr = beat_end ? tile_base(next_x, base_r, stride_r) : rd_addr_o + ADDR_W'(1);
    next_last = (next_beat == v_r) & (next_y == ymax_r) & (next_x == xmax_r);
  end

  // Job configuration is data only; it is meaningful only once a job has been accepted.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      v_r      <= V_dim1_i;
      stride_r <= row_stride_i;
      base_r   <= start_addr_i;
      ymax_r   <= TCNT_W'(U_dim1_i >> TILE_LOG2);
      xmax_r   <= TCNT_W'(ITER_dim1_i >> TILE_LOG2);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      beat      <= '0;
      tile_x_o  <= '0;
      tile_y_o  <= '0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      last_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        state     <= IDLE;
        beat      <= '0;
        tile_x_o  <= '0;
        tile_y_o  <= '0;
        rd_en_o   <= 1'b0;
        rd_addr_o <= '0;
        last_o    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) state <= WAIT_W;
          end
          WAIT_W: begin
            if (weights_rdy_i) begin
              state     <= READ;
              rd_en_o   <= 1'b1;
              rd_addr_o <= tile_base(tile_x_o, base_r, stride_r);
              last_o    <= (beat == v_r) & (tile_y_o == ymax_r) & (tile_x_o == xmax_r);
            end
          end
          READ: begin
            if (fire) begin
              if (last_o) begin
                // Final beat: a job queued on this same fire goes straight to its weight wait.
                state     <= accept ? WAIT_W : IDLE;
                done_o    <= 1'b1;
                rd_en_o   <= 1'b0;
                last_o    <= 1'b0;
                beat      <= '0;
                tile_x_o  <= '0;
                tile_y_o  <= '0;
                rd_addr_o <= '0;
              end else begin
                beat      <= next_beat;
                tile_y_o  <= next_y;
                tile_x_o  <= next_x;
                rd_addr_o <= next_addr;
                last_o    <= next_last;
                if (x_step && (WAIT_PER_COL != 0)) begin
                  state   <= WAIT_W;
                  rd_en_o <= 1'b0;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_unified_buffer_read_sequencer.sv
// Bench for unified_buffer_read_sequencer: directed and random jobs checked beat by
// beat against a tile-walk reference queue; dut_a waits once per job, dut_b per x tile.
module tb_unified_buffer_read_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [7:0]  u1, v1, i1, stride;
  logic [11:0] base;
  logic        weights_rdy, rd_ready, abort;

  logic        a_cfg_ready, a_busy, a_rd_en, a_last, a_done;
  logic [11:0] a_addr;
  logic [2:0]  a_tx, a_ty;
  logic        b_cfg_ready, b_busy, b_rd_en, b_last, b_done;
  logic [11:0] b_addr;
  logic [2:0]  b_tx, b_ty;

  logic        obs_cfg_ready, obs_busy, obs_rd_en, obs_last, obs_done;
  logic [11:0] obs_addr;
  logic [2:0]  obs_tx, obs_ty;

  typedef struct packed {
    logic [11:0] addr;
    logic [2:0]  x;
    logic [2:0]  y;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    sel;
  int    cb_base, cb_stride, cb_v, cb_u, cb_i;
  int    gap;

  always #5 clk = ~clk;

  unified_buffer_read_sequencer #(.WAIT_PER_COL(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a),
    .U_dim1_i(u1), .V_dim1_i(v1), .ITER_dim1_i(i1),
    .start_addr_i(base), .row_stride_i(stride),
    .weights_rdy_i(weights_rdy), .rd_ready_i(rd_ready), .abort_i(abort),
    .cfg_ready_o(a_cfg_ready), .busy_o(a_busy), .rd_en_o(a_rd_en), .rd_addr_o(a_addr),
    .tile_x_o(a_tx), .tile_y_o(a_ty), .last_o(a_last), .done_o(a_done));

  unified_buffer_read_sequencer #(.WAIT_PER_COL(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b),
    .U_dim1_i(u1), .V_dim1_i(v1), .ITER_dim1_i(i1),
    .start_addr_i(base), .row_stride_i(stride),
    .weights_rdy_i(weights_rdy), .rd_ready_i(rd_ready), .abort_i(abort),
    .cfg_ready_o(b_cfg_ready), .busy_o(b_busy), .rd_en_o(b_rd_en), .rd_addr_o(b_addr),
    .tile_x_o(b_tx), .tile_y_o(b_ty), .last_o(b_last), .done_o(b_done));

  always_comb begin
    if (sel) begin
      obs_cfg_ready = b_cfg_ready; obs_busy = b_busy; obs_rd_en = b_rd_en; obs_last = b_last;
      obs_done = b_done; obs_addr = b_addr; obs_tx = b_tx; obs_ty = b_ty;
    end else begin
      obs_cfg_ready = a_cfg_ready; obs_busy = a_busy; obs_rd_en = a_rd_en; obs_last = a_last;
      obs_done = a_done; obs_addr = a_addr; obs_tx = a_tx; obs_ty = a_ty;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: every (x, y, beat) of the job in outer-product order, addresses mod 4096.
  task automatic model(input int b, input int s, input int v, input int u, input int it);
    int    nx, ny;
    beat_t e;
    nx = it / 32 + 1;
    ny = u / 32 + 1;
    for (int x = 0; x < nx; x++)
      for (int y = 0; y < ny; y++)
        for (int k = 0; k <= v; k++) begin
          e.addr = 12'((b + x * s + k) % 4096);
          e.x    = 3'(x);
          e.y    = 3'(y);
          e.last = (x == nx - 1) && (y == ny - 1) && (k == v);
          exp_q.push_back(e);
        end
  endtask

  task automatic set_cfg(input int b, input int s, input int v, input int u, input int it);
    base = 12'(b); stride = 8'(s); v1 = 8'(v); u1 = 8'(u); i1 = 8'(it);
  endtask

  task automatic launch(input int b, input int s, input int v, input int u, input int it);
    @(posedge clk); #1;
    set_cfg(b, s, v, u, it);
    check("launch_cfg_ready", obs_cfg_ready, 1);
    check("launch_idle", obs_busy, 0);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    model(b, s, v, u, it);
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    rd_ready = 1'b1; weights_rdy = 1'b1;
  endtask

  // Drives ready/weights each cycle and checks every displayed beat against the queue head.
  // wmode 1 holds weights low for 5 cycles after an x tile ends; chain queues job cb_* on the final fire.
  task automatic stream(input int rdy_pct, input int wmode, input bit chain, output int gap_o);
    int cyc, wcnt, popped;
    bit done_next, was_due, fin, chain_pending;
    cyc = 0; wcnt = 0; popped = 0; done_next = 0; fin = 0; gap_o = 0;
    chain_pending = chain;
    while (!fin && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (start_a | start_b) check("queue_cfg_ready", obs_cfg_ready, 1);
      check("done", obs_done, done_next);
      was_due = done_next;
      done_next = 0;
      if (obs_rd_en) begin
        if (exp_q.size() == 0) check("extra_beat", obs_rd_en, 0);
        else begin
          check("addr", obs_addr, exp_q[0].addr);
          check("tile_x", obs_tx, exp_q[0].x);
          check("tile_y", obs_ty, exp_q[0].y);
          check("last", obs_last, exp_q[0].last);
          if (rd_ready) begin
            done_next = exp_q[0].last;
            if (wmode == 1 && exp_q.size() > 1 && exp_q[1].x != exp_q[0].x) wcnt = 5;
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end else begin
        check("last_idle", obs_last, 0);
        if (popped > 0 && exp_q.size() > 0) gap_o++;
      end
      if (was_due && exp_q.size() == 0 && !chain_pending) fin = 1;
      if (!fin) begin
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        rd_ready = ($urandom_range(99) < rdy_pct);
        if (wmode == 1) begin
          weights_rdy = (wcnt == 0);
          if (wcnt > 0) wcnt--;
        end else weights_rdy = ($urandom_range(2) != 0);
        if (chain_pending && obs_rd_en && exp_q.size() == 1) begin
          chain_pending = 0;
          rd_ready = 1'b1;
          set_cfg(cb_base, cb_stride, cb_v, cb_u, cb_i);
          if (sel) start_b = 1'b1; else start_a = 1'b1;
          model(cb_base, cb_stride, cb_v, cb_u, cb_i);
        end
      end
    end
    check("stream_finished", fin, 1);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    rd_ready = 1'b0; weights_rdy = 1'b0; sel = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_cfg_ready", obs_cfg_ready, 1);
      check("rst_busy", obs_busy, 0);
      check("rst_rd_en", obs_rd_en, 0);
      check("rst_addr", obs_addr, 0);
      check("rst_tiles", {obs_tx, obs_ty}, 0);
      check("rst_last_done", {obs_last, obs_done}, 0);
    end
    @(negedge clk); rst_n = 1'b1;

    sel = 1'b0;
    launch(12'h010, 0, 3, 0, 0);            // four beats 10..13
    stream(100, 0, 0, gap);
    launch(0, 8, 1, 32, 32);                // 2x2 tiles, 2 beats each
    stream(100, 1, 0, gap);
    check("single_wait_gap", gap, 0);
    launch(0, 8, 1, 32, 32);                // same walk under random stalls
    stream(55, 0, 0, gap);

    sel = 1'b1;
    launch(0, 8, 1, 32, 32);                // per-x-tile weight wait, 5-cycle delay
    stream(100, 1, 0, gap);
    check("per_col_gap", gap, 6);

    sel = 1'b0;
    cb_base = 12'h200; cb_stride = 4; cb_v = 2; cb_u = 0; cb_i = 40;
    launch(12'h010, 0, 3, 0, 0);            // job B queued on A's final fire
    stream(100, 0, 1, gap);
    launch(12'hFFE, 0, 3, 0, 0);            // address wrap
    stream(70, 0, 0, gap);

    for (int j = 0; j < 16; j++) begin
      sel = $urandom_range(1);
      cb_base = $urandom_range(4095); cb_stride = $urandom_range(255);
      cb_v = $urandom_range(5); cb_u = $urandom_range(95); cb_i = $urandom_range(95);
      launch($urandom_range(4095), $urandom_range(255), $urandom_range(7),
             $urandom_range(95), $urandom_range(95));
      stream($urandom_range(100, 30), 0, ($urandom_range(3) == 0), gap);
    end

    sel = 1'b0;
    launch(0, 8, 1, 32, 32);
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_busy", obs_busy, 1);
    check("abort_pre_rd_en", obs_rd_en, 1);
    abort = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start_a = 1'b0;
    check("abort_busy", obs_busy, 0);
    check("abort_rd_en", obs_rd_en, 0);
    check("abort_tiles", {obs_tx, obs_ty}, 0);
    check("abort_last_done", {obs_last, obs_done}, 0);
    check("abort_cfg_ready", obs_cfg_ready, 1);
    @(posedge clk); #1;
    check("abort_no_done", obs_done, 0);
    check("abort_start_ignored", obs_busy, 0);
    exp_q.delete();

    launch(12'h100, 3, 3, 64, 64);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cfg_ready", obs_cfg_ready, 1);
    check("midrst_busy", obs_busy, 0);
    check("midrst_rd_en", obs_rd_en, 0);
    check("midrst_addr", obs_addr, 0);
    check("midrst_tiles", {obs_tx, obs_ty}, 0);
    check("midrst_last_done", {obs_last, obs_done}, 0);
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
